npu_read_sequencer: RTL and testbench

- Read-side controller for the NPU memory block.
- Sequences synchronous reads from the four image RAMs (shared 14-bit address) and the conv weight RAM (16-bit address), then streams the results to the convolution datapath over a valid/ready interface.
- For each filter it reads one bias byte, then IMG_WORDS pairs of (32-bit pixel word, 8-bit weight).
- It also absorbs the 1-cycle RAM read latency and consumer backpressure.

---
 rtl/npu_read_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_npu_read_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_read_sequencer.sv
// npu_read_sequencer: read-side controller for the NPU memory block.
// It reads one bias byte and IMG_WORDS (pixel word, weight) pairs per filter.
// Results are streamed over valid/ready through a 2-entry output FIFO.
// Optional: define NPU_SEQ_PERF_EN to add the perf_stall_cycles counter.
module npu_read_sequencer #(
  parameter int unsigned IMG_WORDS = 196,
  parameter int unsigned IMG_AW    = 14,
  parameter int unsigned CONV_AW   = 16,
  parameter int unsigned FILT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [FILT_W-1:0]  cfg_num_filters,
  output logic               busy,
  output logic               done,
  output logic [IMG_AW-1:0]  img_addr,
  output logic [CONV_AW-1:0] conv_addr,
  input  logic [7:0]         img_q0,
  input  logic [7:0]         img_q1,
  input  logic [7:0]         img_q2,
  input  logic [7:0]         img_q3,
  input  logic [7:0]         conv_q,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_bias,
  output logic               out_last,
  output logic [FILT_W-1:0]  out_filter,
  output logic [31:0]        out_pixels,
  output logic [7:0]         out_weight
`ifdef NPU_SEQ_PERF_EN
  ,
  output logic [31:0]        perf_stall_cycles
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    READ_BIAS,
    READ_DATA,
    READ_STALL,
    READ_FINAL
  } state_t;

  typedef struct packed {
    logic              bias;
    logic              last;
    logic [FILT_W-1:0] filter;
  } tag_t;

  typedef struct packed {
    tag_t        tag;
    logic [31:0] pixels;
    logic [7:0]  weight;
  } beat_t;

  state_t            state;
  state_t            stall_ret;
  logic [FILT_W-1:0] filt;
  logic [FILT_W-1:0] num_filters;
  logic              rd_pend;
  tag_t              rd_tag;
  beat_t             fifo0;
  beat_t             fifo1;
  logic [1:0]        count;

  logic  xfer;
  logic  credit;
  logic  data_last;
  logic  more_filt;
  logic  kill;
  beat_t rd_beat;

  // Credit counts the FIFO slots already promised to reads in flight.
  always_comb begin
    xfer      = out_valid && out_ready;
    credit    = (({1'b0, count} + {2'b00, rd_pend}) - {2'b00, xfer}) < 3'd2;
    data_last = (img_addr == IMG_AW'(IMG_WORDS - 1));
    more_filt = (({1'b0, filt} + (FILT_W + 1)'(1)) < {1'b0, num_filters});
    kill      = abort && (state != IDLE);
    rd_beat.tag    = rd_tag;
    rd_beat.pixels = rd_tag.bias ? '0 : {img_q0, img_q1, img_q2, img_q3};
    rd_beat.weight = conv_q;
  end

  assign busy       = (state != IDLE);
  assign out_valid  = (count != 2'd0);
  assign out_bias   = fifo0.tag.bias;
  assign out_last   = fifo0.tag.last;
  assign out_filter = fifo0.tag.filter;
  assign out_pixels = fifo0.pixels;
  assign out_weight = fifo0.weight;

  // Sequencer: addresses advance as each read is issued; the RAM samples the current address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      stall_ret   <= IDLE;
      filt        <= '0;
      num_filters <= '0;
      img_addr    <= '0;
      conv_addr   <= '0;
      rd_pend     <= 1'b0;
      rd_tag      <= '0;
      done        <= 1'b0;
    end else begin
      done    <= 1'b0;
      rd_pend <= 1'b0;
      if (kill) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              if (cfg_num_filters == '0) begin
                done <= 1'b1;
              end else begin
                num_filters <= cfg_num_filters;
                filt        <= '0;
                img_addr    <= '0;
                conv_addr   <= '0;
                state       <= READ_BIAS;
              end
            end
          end
          READ_BIAS: begin
            if (credit) begin
              rd_pend   <= 1'b1;
              rd_tag    <= '{bias: 1'b1, last: 1'b0, filter: filt};
              conv_addr <= conv_addr + CONV_AW'(1);
              state     <= READ_DATA;
            end else begin
              stall_ret <= READ_BIAS;
              state     <= READ_STALL;
            end
          end
          READ_DATA: begin
            if (credit) begin
              rd_pend   <= 1'b1;
              rd_tag    <= '{bias: 1'b0, last: data_last, filter: filt};
              conv_addr <= conv_addr + CONV_AW'(1);
              if (data_last) begin
                img_addr <= '0;
                if (more_filt) begin
                  filt  <= filt + FILT_W'(1);
                  state <= READ_BIAS;
                end else begin
                  state <= READ_FINAL;
                end
              end else begin
                img_addr <= img_addr + IMG_AW'(1);
              end
            end else begin
              stall_ret <= READ_DATA;
              state     <= READ_STALL;
            end
          end
          READ_STALL: begin
            if (credit) state <= stall_ret;
          end
          READ_FINAL: begin
            if (!rd_pend && (count == 2'd0)) begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Output FIFO held as a shift pair so the head is always fifo0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 2'd0;
      fifo0 <= '0;
      fifo1 <= '0;
    end else if (kill) begin
      count <= 2'd0;
    end else begin
      case ({rd_pend, xfer})
        2'b10: begin
          if (count == 2'd0) fifo0 <= rd_beat;
          else               fifo1 <= rd_beat;
          count <= count + 2'd1;
        end
        2'b01: begin
          fifo0 <= fifo1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            fifo0 <= rd_beat;
          end else begin
            fifo0 <= fifo1;
            fifo1 <= rd_beat;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef NPU_SEQ_PERF_EN
  // Saturating count of cycles spent waiting for credit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cycles <= '0;
    end else if ((state == IDLE) && start && !abort) begin
      perf_stall_cycles <= '0;
    end else if ((state == READ_STALL) && (perf_stall_cycles != '1)) begin
      perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_npu_read_sequencer.sv
// Testbench for npu_read_sequencer with IMG_WORDS=4 and small behavioural RAMs.
module tb_npu_read_sequencer;

  localparam int unsigned IMG_WORDS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  cfg_num_filters;
  logic        busy;
  logic        done;
  logic [13:0] img_addr;
  logic [15:0] conv_addr;
  logic [7:0]  img_q0, img_q1, img_q2, img_q3, conv_q;
  logic        out_valid;
  logic        out_ready;
  logic        out_bias;
  logic        out_last;
  logic [7:0]  out_filter;
  logic [31:0] out_pixels;
  logic [7:0]  out_weight;
`ifdef NPU_SEQ_PERF_EN
  logic [31:0] perf_stall_cycles;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  npu_read_sequencer #(
    .IMG_WORDS(IMG_WORDS),
    .IMG_AW(14),
    .CONV_AW(16),
    .FILT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .cfg_num_filters(cfg_num_filters),
    .busy(busy),
    .done(done),
    .img_addr(img_addr),
    .conv_addr(conv_addr),
    .img_q0(img_q0),
    .img_q1(img_q1),
    .img_q2(img_q2),
    .img_q3(img_q3),
    .conv_q(conv_q),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bias(out_bias),
    .out_last(out_last),
    .out_filter(out_filter),
    .out_pixels(out_pixels),
    .out_weight(out_weight)
`ifdef NPU_SEQ_PERF_EN
    ,
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  function automatic logic [7:0] img_val(int unsigned b, int unsigned a);
    return 8'(32'hA0 + b * 16 + a);
  endfunction

  function automatic logic [7:0] conv_val(int unsigned a);
    return 8'(a * 3 + 7);
  endfunction

  // Synchronous-read RAMs: address sampled on the edge, data valid after it.
  logic [7:0] img_mem [4][16];
  logic [7:0] conv_mem [64];

  initial begin
    for (int unsigned b = 0; b < 4; b++)
      for (int unsigned a = 0; a < 16; a++)
        img_mem[b][a] = img_val(b, a);
    for (int unsigned a = 0; a < 64; a++)
      conv_mem[a] = conv_val(a);
  end

  always @(posedge clk) begin
    img_q0 <= img_mem[0][img_addr[3:0]];
    img_q1 <= img_mem[1][img_addr[3:0]];
    img_q2 <= img_mem[2][img_addr[3:0]];
    img_q3 <= img_mem[3][img_addr[3:0]];
    conv_q <= conv_mem[conv_addr[5:0]];
  end

  // Expected beat k of a pass: {bias, last, filter, pixels, weight}.
  function automatic logic [49:0] exp_beat(int unsigned k);
    int unsigned f, j, i;
    f = k / (IMG_WORDS + 1);
    j = k % (IMG_WORDS + 1);
    if (j == 0)
      return {1'b1, 1'b0, 8'(f), 32'h0, conv_val(f * (IMG_WORDS + 1))};
    i = j - 1;
    return {1'b0, (i == IMG_WORDS - 1), 8'(f),
            img_val(0, i), img_val(1, i), img_val(2, i), img_val(3, i),
            conv_val(f * (IMG_WORDS + 1) + 1 + i)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  nf;
    int unsigned mode;       // 0: ready=1, 1: toggle, 2: toggle then hold 0 for 10 cycles
    bit          poke;       // pulse start mid-pass
    int unsigned exp_beats;
    int unsigned exp_first;  // cycle of first out_valid after start, 0 = not checked
    int unsigned exp_done;   // cycle of done pulse after start, 0 = not checked
  } vec_t;

  vec_t vecs[5];

  task automatic run_pass(input vec_t v, input string tag);
    int unsigned k, cyc, done_seen, done_cyc, first;
    logic [13:0] sv_img;
    logic [15:0] sv_conv;
    k = 0; cyc = 0; done_seen = 0; done_cyc = 0; first = 0;
    sv_img = '0; sv_conv = '0;
    @(negedge clk);
    cfg_num_filters = v.nf;
    start = 1'b1;
    out_ready = 1'b1;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (v.poke && cyc == 6) begin
        start = 1'b1;
        cfg_num_filters = 8'd3;
      end
      case (v.mode)
        1: out_ready = cyc[0];
        2: out_ready = (cyc <= 12) ? cyc[0] : (cyc > 22);
        default: out_ready = 1'b1;
      endcase
      if (v.mode == 2 && cyc == 16) begin
        sv_img = img_addr;
        sv_conv = conv_addr;
      end
      if (v.mode == 2 && cyc == 22) begin
        check({tag, " img_addr_frozen"}, 64'(img_addr), 64'(sv_img));
        check({tag, " conv_addr_frozen"}, 64'(conv_addr), 64'(sv_conv));
      end
      if (out_valid && first == 0) first = cyc;
      if (out_valid && out_ready) begin
        check($sformatf("%s beat%0d", tag, k),
              64'({out_bias, out_last, out_filter, out_pixels, out_weight}), 64'(exp_beat(k)));
        k++;
      end
      if (done) begin
        done_seen++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (done_seen != 0 && cyc >= done_cyc + 2) break;
    end
    check({tag, " done_count"}, 64'(done_seen), 64'd1);
    check({tag, " beat_count"}, 64'(k), 64'(v.exp_beats));
    check({tag, " busy_after"}, 64'(busy), 64'd0);
    if (v.exp_first != 0) check({tag, " first_valid_cyc"}, 64'(first), 64'(v.exp_first));
    if (v.exp_done != 0) check({tag, " done_cyc"}, 64'(done_cyc), 64'(v.exp_done));
`ifdef NPU_SEQ_PERF_EN
    if (v.mode == 2) check({tag, " perf_nonzero"}, 64'(perf_stall_cycles != 0), 64'd1);
`endif
  endtask

  initial begin
    int unsigned k;
    int unsigned bad_done, bad_valid;

    vecs[0] = '{nf: 8'd1, mode: 0, poke: 1'b0, exp_beats: 5,  exp_first: 3, exp_done: 9};
    vecs[1] = '{nf: 8'd2, mode: 0, poke: 1'b1, exp_beats: 10, exp_first: 3, exp_done: 14};
    vecs[2] = '{nf: 8'd3, mode: 1, poke: 1'b0, exp_beats: 15, exp_first: 3, exp_done: 0};
    vecs[3] = '{nf: 8'd2, mode: 2, poke: 1'b0, exp_beats: 10, exp_first: 3, exp_done: 0};
    vecs[4] = '{nf: 8'd0, mode: 0, poke: 1'b0, exp_beats: 0,  exp_first: 0, exp_done: 1};

    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0; cfg_num_filters = '0;
    #1;
    check("reset_ctrl", 64'({out_valid, busy, done, out_bias, out_last, out_filter, out_weight}), 64'd0);
    check("reset_data", 64'({img_addr, conv_addr, out_pixels}), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int unsigned n = 0; n < 5; n++)
      run_pass(vecs[n], $sformatf("vec%0d", n));

    // abort together with start while idle: nothing starts
    @(negedge clk);
    abort = 1'b1; start = 1'b1; cfg_num_filters = 8'd0;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("idle_abort_start", 64'({busy, done}), 64'd0);

    // abort after three beats, with a concurrent start that must lose
    @(negedge clk);
    cfg_num_filters = 8'd2; start = 1'b1; out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 40 && k < 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && out_ready) begin
        check($sformatf("abort beat%0d", k),
              64'({out_bias, out_last, out_filter, out_pixels, out_weight}), 64'(exp_beat(k)));
        k++;
      end
    end
    check("abort_pre_beats", 64'(k), 64'd3);
    @(negedge clk);
    out_ready = 1'b0; abort = 1'b1; start = 1'b1; cfg_num_filters = 8'd1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("abort_state", 64'({out_valid, busy, done}), 64'd0);
    out_ready = 1'b1;
    bad_done = 0; bad_valid = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) bad_done++;
      if (out_valid || busy) bad_valid++;
    end
    check("abort_no_done", 64'(bad_done), 64'd0);
    check("abort_quiet", 64'(bad_valid), 64'd0);
    run_pass(vecs[0], "restart");

    // asynchronous reset between edges in the middle of a pass
    @(negedge clk);
    cfg_num_filters = 8'd2; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_ctrl", 64'({out_valid, busy, done, out_bias, out_last, out_filter, out_weight}), 64'd0);
    check("async_reset_data", 64'({img_addr, conv_addr, out_pixels}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_pass(vecs[1], "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
